// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers one decoded instruction, resolves EX/MEM and MEM/WB
// forwarding, selects PC/immediate operands and stalls on load-use hazards.
module alu_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [4:0]      in_rs1_addr,
   input  logic [4:0]      in_rs2_addr,
   input  logic [4:0]      in_rd_addr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic            in_rs1_used,
   input  logic            in_rs2_used,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   input  logic            in_use_pc,
   input  logic [3:0]      in_alu_op,
   input  logic            in_reg_write,
   input  logic            exm_reg_write,
   input  logic            exm_mem_read,
   input  logic [4:0]      exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_result,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] SrcA,
   output logic [XLEN-1:0] SrcB,
   output logic [3:0]      ALUOp,
   output logic [XLEN-1:0] out_store_data,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic [XLEN-1:0] out_pc
);

   logic            vld_q, vld_d;
   logic [XLEN-1:0] src_a_q, src_a_d;
   logic [XLEN-1:0] src_b_q, src_b_d;
   logic [XLEN-1:0] store_q, store_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [4:0]      rd_q, rd_d;
   logic            reg_write_q, reg_write_d;

   logic [XLEN-1:0] fwd_rs1, fwd_rs2;
   logic            hazard_src;
   logic            capture;

   // A load in EX/MEM has no result yet, so it is never a forwarding source.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rf_data,
      input logic            exm_we,
      input logic            exm_ld,
      input logic [4:0]      exm_dst,
      input logic [XLEN-1:0] exm_val,
      input logic            wb_we,
      input logic [4:0]      wb_dst,
      input logic [XLEN-1:0] wb_val
   );
      if (exm_we && !exm_ld && exm_dst == rs && rs != 5'd0)
         return exm_val;
      else if (wb_we && wb_dst == rs && rs != 5'd0)
         return wb_val;
      else
         return rf_data;
   endfunction

   always_comb begin
      fwd_rs1 = fwd_sel(in_rs1_addr, in_rs1_data, exm_reg_write, exm_mem_read, exm_rd,
                        exm_result, wb_reg_write, wb_rd, wb_result);
      fwd_rs2 = fwd_sel(in_rs2_addr, in_rs2_data, exm_reg_write, exm_mem_read, exm_rd,
                        exm_result, wb_reg_write, wb_rd, wb_result);

      // Hazard term without in_valid keeps in_ready free of any in_valid path;
      // capture still requires in_valid, so acceptance behaviour is identical.
      hazard_src = exm_mem_read && (exm_rd != 5'd0) &&
                   ((in_rs1_used && exm_rd == in_rs1_addr) ||
                    (in_rs2_used && exm_rd == in_rs2_addr));

      in_ready = (!vld_q || out_ready) && !hazard_src && !flush;
      capture  = in_valid && in_ready;

      src_a_d     = src_a_q;
      src_b_d     = src_b_q;
      store_d     = store_q;
      pc_d        = pc_q;
      alu_op_d    = alu_op_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      if (capture) begin
         src_a_d     = in_use_pc  ? in_pc  : fwd_rs1;
         src_b_d     = in_use_imm ? in_imm : fwd_rs2;
         store_d     = fwd_rs2;
         pc_d        = in_pc;
         alu_op_d    = in_alu_op;
         rd_d        = in_rd_addr;
         reg_write_d = in_reg_write;
      end

      if (flush)
         vld_d = 1'b0;
      else if (capture)
         vld_d = 1'b1;
      else if (vld_q && !out_ready)
         vld_d = 1'b1;
      else
         vld_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= 1'b0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         store_q     <= '0;
         pc_q        <= '0;
         alu_op_q    <= 4'b0000;
         rd_q        <= 5'd0;
         reg_write_q <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         store_q     <= store_d;
         pc_q        <= pc_d;
         alu_op_q    <= alu_op_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign out_valid      = vld_q;
   assign SrcA           = src_a_q;
   assign SrcB           = src_b_q;
   assign out_store_data = store_q;
   assign out_pc         = pc_q;
   assign ALUOp          = alu_op_q;
   assign out_rd         = rd_q;
   // Bubbles may keep stale data, but must never request a register write.
   assign out_reg_write  = reg_write_q && vld_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: table of forwarding/operand vectors through a scoreboard
// queue, plus hand sequences for load-use, backpressure, flush and async reset.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic        in_rs1_used, in_rs2_used, in_use_imm, in_use_pc, in_reg_write;
   logic [3:0]  in_alu_op;
   logic        exm_reg_write, exm_mem_read, wb_reg_write, flush, out_valid, out_ready;
   logic [4:0]  exm_rd, wb_rd, out_rd;
   logic [31:0] exm_result, wb_result, SrcA, SrcB, out_store_data, out_pc;
   logic [3:0]  ALUOp;
   logic        out_reg_write;

   always #5 clk = ~clk;

   alu_operand_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_alu_op(in_alu_op),
      .in_reg_write(in_reg_write), .exm_reg_write(exm_reg_write),
      .exm_mem_read(exm_mem_read), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
      .ALUOp(ALUOp), .out_store_data(out_store_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_pc(out_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs1a; logic [31:0] rs1d; logic rs1u;
      logic [4:0]  rs2a; logic [31:0] rs2d; logic rs2u;
      logic [31:0] imm;  logic use_imm; logic use_pc;
      logic [3:0]  op;   logic [4:0] rd; logic rw;
      logic        exm_rw; logic exm_mr; logic [4:0] exm_rd; logic [31:0] exm_res;
      logic        wb_rw;  logic [4:0] wb_rd; logic [31:0] wb_res;
      logic [31:0] exp_a; logic [31:0] exp_b; logic [31:0] exp_st;
   } vec_t;

   typedef struct {
      logic [31:0] a, b, st, pc;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   exp_t held;
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mkv(
      logic [31:0] pc, logic [4:0] rs1a, logic [31:0] rs1d, logic rs1u,
      logic [4:0] rs2a, logic [31:0] rs2d, logic rs2u, logic [31:0] imm,
      logic use_imm, logic use_pc, logic [3:0] op, logic [4:0] rd, logic rw,
      logic exm_rw, logic exm_mr, logic [4:0] erd, logic [31:0] eres,
      logic wb_rw, logic [4:0] wrd, logic [31:0] wres,
      logic [31:0] ea, logic [31:0] eb, logic [31:0] est);
      vec_t v;
      v.pc = pc; v.rs1a = rs1a; v.rs1d = rs1d; v.rs1u = rs1u;
      v.rs2a = rs2a; v.rs2d = rs2d; v.rs2u = rs2u; v.imm = imm;
      v.use_imm = use_imm; v.use_pc = use_pc; v.op = op; v.rd = rd; v.rw = rw;
      v.exm_rw = exm_rw; v.exm_mr = exm_mr; v.exm_rd = erd; v.exm_res = eres;
      v.wb_rw = wb_rw; v.wb_rd = wrd; v.wb_res = wres;
      v.exp_a = ea; v.exp_b = eb; v.exp_st = est;
      return v;
   endfunction

   function automatic exp_t to_exp(vec_t v);
      exp_t e;
      e.a = v.exp_a; e.b = v.exp_b; e.st = v.exp_st; e.pc = v.pc;
      e.op = v.op; e.rd = v.rd; e.rw = v.rw;
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      in_valid = 1'b1;
      in_pc = v.pc; in_rs1_addr = v.rs1a; in_rs1_data = v.rs1d; in_rs1_used = v.rs1u;
      in_rs2_addr = v.rs2a; in_rs2_data = v.rs2d; in_rs2_used = v.rs2u;
      in_imm = v.imm; in_use_imm = v.use_imm; in_use_pc = v.use_pc;
      in_alu_op = v.op; in_rd_addr = v.rd; in_reg_write = v.rw;
      exm_reg_write = v.exm_rw; exm_mem_read = v.exm_mr; exm_rd = v.exm_rd;
      exm_result = v.exm_res;
      wb_reg_write = v.wb_rw; wb_rd = v.wb_rd; wb_result = v.wb_res;
   endtask

   task automatic cmp_out(string tag, exp_t e);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".SrcA"}, SrcA, e.a);
      chk({tag, ".SrcB"}, SrcB, e.b);
      chk({tag, ".store"}, out_store_data, e.st);
      chk({tag, ".ALUOp"}, {28'd0, ALUOp}, {28'd0, e.op});
      chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, e.rd});
      chk({tag, ".reg_write"}, {31'd0, out_reg_write}, {31'd0, e.rw});
      chk({tag, ".pc"}, out_pc, e.pc);
   endtask

   task automatic pop_cmp(string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++; fails++;
         $display("FAIL %s.scoreboard: got empty queue required one entry", tag);
      end else begin
         e = sb.pop_front();
         cmp_out(tag, e);
         held = e;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".reg_write"}, {31'd0, out_reg_write}, 32'd0);
      chk({tag, ".SrcA"}, SrcA, 32'd0);
      chk({tag, ".SrcB"}, SrcB, 32'd0);
      chk({tag, ".store"}, out_store_data, 32'd0);
      chk({tag, ".pc"}, out_pc, 32'd0);
      chk({tag, ".rd"}, {27'd0, out_rd}, 32'd0);
      chk({tag, ".ALUOp"}, {28'd0, ALUOp}, 32'd0);
   endtask

   initial begin
      //          pc     rs1 rs1d      u  rs2 rs2d        u  imm          ui up op rd rw  exm:rw mr rd res      wb:rw rd res     expA      expB         expSt
      vecs[0] = mkv(32'h40, 1, 32'h5,    1, 0,  32'h0,    0, 32'h7,       1, 0, 0, 2, 1,  0, 0, 0, 32'h0,      0, 0, 32'h0,     32'h5,     32'h7,       32'h0);
      vecs[1] = mkv(32'h44, 3, 32'h1,    1, 4,  32'h33,   1, 32'h0,       0, 0, 1, 5, 1,  1, 0, 3, 32'h10,     1, 3, 32'h20,    32'h10,    32'h33,      32'h33);
      vecs[2] = mkv(32'h48, 3, 32'h1,    1, 4,  32'h33,   1, 32'h0,       0, 0, 2, 5, 1,  0, 0, 3, 32'h10,     1, 3, 32'h20,    32'h20,    32'h33,      32'h33);
      vecs[3] = mkv(32'h4C, 0, 32'h0,    1, 0,  32'h0,    1, 32'h0,       0, 0, 3, 6, 1,  1, 0, 0, 32'hFF,     1, 0, 32'hEE,    32'h0,     32'h0,       32'h0);
      vecs[4] = mkv(32'h100,0, 32'h0,    1, 0,  32'h0,    0, 32'h14,      1, 1, 0, 1, 1,  1, 0, 0, 32'hFF,     0, 0, 32'h0,     32'h100,   32'h14,      32'h0);
      vecs[5] = mkv(32'h104,8, 32'h80,   1, 9,  32'h90,   1, 32'hFFFFFFF0,1, 0, 4,10, 0,  1, 0, 9, 32'hAB,     1, 8, 32'hCD,    32'hCD,    32'hFFFFFFF0,32'hAB);
      vecs[6] = mkv(32'h108,7, 32'h70,   0, 2,  32'h22,   1, 32'h0,       0, 0, 5,11, 1,  1, 1, 7, 32'h99,     1, 7, 32'h77,    32'h77,    32'h22,      32'h22);
      vecs[7] = mkv(32'h10C,12,32'hC,    1, 13, 32'hD,    1, 32'h0,       0, 0,15,31, 1,  1, 0,13, 32'h1313,   1,12, 32'h1212,  32'h1212,  32'h1313,    32'h1313);

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      apply(vecs[0]);
      in_valid = 1'b0;
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back table vectors, one per cycle
      for (int i = 0; i < 8; i++) begin
         apply(vecs[i]);
         #0;
         chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
         sb.push_back(to_exp(vecs[i]));
         step();
         pop_cmp($sformatf("vec%0d", i));
      end

      // Load-use: rs2 depends on a load in EX/MEM
      apply(mkv(32'h200, 1, 32'h1, 0, 5, 32'h55, 1, 32'h0, 0, 0, 0, 9, 1,
                1, 1, 5, 32'h99, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0));
      #0;
      chk("loaduse.in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("loaduse.bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("loaduse.bubble_rw", {31'd0, out_reg_write}, 32'd0);
      apply(mkv(32'h200, 1, 32'h1, 0, 5, 32'h55, 1, 32'h0, 0, 0, 0, 9, 1,
                0, 0, 5, 32'h99, 1, 5, 32'h2A, 32'h1, 32'h2A, 32'h2A));
      #0;
      chk("loaduse.resume_ready", {31'd0, in_ready}, 32'd1);
      sb.push_back(to_exp(mkv(32'h200, 1, 32'h1, 0, 5, 32'h55, 1, 32'h0, 0, 0, 0, 9, 1,
                              0, 0, 5, 32'h99, 1, 5, 32'h2A, 32'h1, 32'h2A, 32'h2A)));
      step();
      pop_cmp("loaduse");

      // Backpressure: outputs hold while inputs keep changing
      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         apply(vecs[k]);
         #0;
         chk($sformatf("bp%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
         step();
         cmp_out($sformatf("bp%0d", k), held);
      end
      out_ready = 1'b1;
      apply(vecs[7]);
      #0;
      chk("bp_release.in_ready", {31'd0, in_ready}, 32'd1);
      sb.push_back(to_exp(vecs[7]));
      step();
      pop_cmp("bp_release");

      // Flush overrides a capture
      apply(vecs[1]);
      flush = 1'b1;
      #0;
      chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush.reg_write", {31'd0, out_reg_write}, 32'd0);

      // Flush overrides a hold under backpressure
      flush = 1'b0;
      apply(vecs[2]);
      sb.push_back(to_exp(vecs[2]));
      step();
      pop_cmp("flush_hold.pre");
      out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
      step();
      chk("flush_hold.out_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0; out_ready = 1'b1;

      // Async reset in the middle of a stall
      apply(vecs[3]);
      sb.push_back(to_exp(vecs[3]));
      step();
      pop_cmp("rst_stall.pre");
      out_ready = 1'b0;
      apply(vecs[4]);
      step();
      cmp_out("rst_stall.hold", held);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("rst_stall");
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      apply(vecs[5]);
      #0;
      chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
      sb.push_back(to_exp(vecs[5]));
      step();
      pop_cmp("post_rst");

      in_valid = 1'b0;
      step();
      chk("idle.out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle.reg_write", {31'd0, out_reg_write}, 32'd0);
      chk("sb.empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that feeds ALU_core. Registers one decoded instruction per cycle, resolves operand forwarding from the EX/MEM and MEM/WB stages, and selects the PC or immediate operands. It detects load-use hazards and drives registered `SrcA`, `SrcB` and `ALUOp` plus the sideband needed downstream. Uses a valid/ready handshake on both sides, with flush support.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_pc`  in  32  instruction PC.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each  register indices.
- `in_rs1_data`, `in_rs2_data`  in  32 each  register-file read data.
- `in_rs1_used`, `in_rs2_used`  in  1 each  operand actually consumed (for hazard check).
- `in_imm`  in  32  sign-extended immediate.
- `in_use_imm`  in  1  `SrcB` = `in_imm`.
- `in_use_pc`  in  1  `SrcA` = `in_pc` (AUIPC/JAL).
- `in_alu_op`  in  4  ALU operation code from defines.v.
- `in_reg_write`  in  1  instruction writes rd.
- `exm_reg_write`  in  1  EX/MEM forwarding source valid.
- `exm_mem_read`  in  1  EX/MEM instruction is a load.
- `exm_rd`  in  5  EX/MEM destination.
- `exm_result`  in  32  EX/MEM result.
- `wb_reg_write`  in  1  MEM/WB forwarding source valid.
- `wb_rd`  in  5  MEM/WB destination.
- `wb_result`  in  32  MEM/WB result.
- `flush`  in  1  kill the held instruction (branch redirect).
- `out_valid`  out  1  registered outputs are valid.
- `out_ready`  in  1  EX stage consumes this cycle.
- `SrcA`, `SrcB`  out  32 each  ALU operands.
- `ALUOp`  out  4  ALU operation code.
- `out_store_data`  out  32  forwarded rs2 value, for stores.
- `out_rd`  out  5  destination register.
- `out_reg_write`  out  1  write enable, gated by `out_valid`.
- `out_pc`  out  32  PC passthrough.

## Operation
Forwarding is a per-operand mux, evaluated combinationally before the register:
- Operand `rsN` takes `exm_result` if `exm_reg_write && exm_rd==rsN && rsN!=0 && !exm_mem_read`.
- Otherwise it takes `wb_result` if `wb_reg_write && wb_rd==rsN && rsN!=0`.
- Otherwise it takes `in_rsN_data`.
- EX/MEM has priority over MEM/WB.
- x0 is never forwarded.

Operand select:
- `SrcA` = `in_use_pc` ? `in_pc` : fwd_rs1.
- `SrcB` = `in_use_imm` ? `in_imm` : fwd_rs2.
- `out_store_data` = fwd_rs2 always.

Load-use hazard:
- Raised when `in_valid && exm_mem_read && exm_rd!=0 && ((in_rs1_used && exm_rd==in_rs1_addr) || (in_rs2_used && exm_rd==in_rs2_addr))`.
- The instruction is not accepted while the hazard holds.

Handshake:
- `in_ready` = (`!out_valid || out_ready`) && `!hazard` && `!flush`.
- Capture when `in_valid && in_ready`: all outputs load and `out_valid`←1.

Output state, per cycle:
- `flush`=1: `out_valid`←0. This overrides a capture and a pending `out_ready`.
- `out_valid && !out_ready` (no flush): all outputs hold, bit-stable.
- `out_ready` (or `!out_valid`) with no capture, including the hazard case: `out_valid`←0. This is a bubble; the data registers may hold stale values, but `out_reg_write` must read 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle with `out_ready`=1 and no hazards.
- Load-use costs exactly 1 bubble when the load advances from EX/MEM in the next cycle.
- Reset (async, any time, including mid-stall): `out_valid`=0 and `out_reg_write`=0. `SrcA`, `SrcB`, `out_store_data`, `out_pc`=0; `out_rd`=0; `ALUOp`=4'b0000. All take effect immediately, with no edge required.
- First capture is possible on the first rising edge after `rst` deasserts.
- `in_ready` is combinational from `out_valid`, `out_ready`, `flush` and the hazard inputs. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- Basic: rs1_data=5, imm=7, `in_use_imm`=1, ADD op, `in_valid`=1, `out_ready`=1 -> next cycle `out_valid`=1, `SrcA`=5, `SrcB`=7.
- Forward priority: rs1=3, rs1_data=1, exm(rd=3, 0x10), wb(rd=3, 0x20) -> `SrcA`=0x10. With `exm_reg_write`=0 -> `SrcA`=0x20.
- x0: rs1=0, rs1_data=0, exm(rd=0, 0xFF, write=1) -> `SrcA`=0. Also `in_use_pc`=1, pc=0x100 -> `SrcA`=0x100.
- Load-use: `exm_mem_read`=1, exm_rd=5, rs2=5, `in_rs2_used`=1 -> `in_ready`=0. Next cycle `out_valid`=0, `out_reg_write`=0. After `exm_mem_read` drops and wb(rd=5, 0x2A) -> `SrcB`=0x2A, `out_store_data`=0x2A.
- Backpressure: `out_valid`=1, `out_ready`=0 for 3 cycles while inputs change -> all outputs stable, `in_ready`=0. Raising `out_ready` accepts the next instruction.
- Flush and reset: `flush`=1 while `in_valid`=1 -> next cycle `out_valid`=0. Assert `rst` mid-stall between edges -> all outputs go to 0 immediately, with no edge needed.
